// File: rtl/gray_position_decoder_pkg.sv
// Shared types and helpers for the Gray position decoder: FSM states,
// turn-counter width and the Gray-to-binary conversion.
package gray_pkg;

  localparam int TURN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it;
  // zero-extended upper bits leave narrower codes unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_in_filter.sv
// Two-flop synchroniser plus stability filter for the asynchronous Gray input.
// Raises accept for exactly one cycle when a new code has been stable long enough.
module gray_in_filter #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] cand,
  output logic             accept
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] last_code;
  logic [WIDTH-1:0] cand_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Acceptance is judged on the filter's next state so the decision lands in
  // the same cycle the code completes its stable run, not one cycle later.
  always_comb begin
    cand_nxt = cand_q;
    cnt_nxt  = cnt;
    if (sync_q2 != cand_q) begin
      cand_nxt = sync_q2;
      cnt_nxt  = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  assign accept = (cnt_nxt == CNT_MAX) && (cand_nxt != last_code);
  assign cand   = cand_nxt;

  // Synchroniser stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gray_in;
      sync_q2 <= sync_q1;
    end
  end

  // Stability filter stage; last_code advances even when the FSM is frozen,
  // so a code accepted while disabled is never offered again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= '0;
      cnt       <= '0;
      last_code <= '0;
    end else begin
      cand_q <= cand_nxt;
      cnt    <= cnt_nxt;
      if (accept) begin
        last_code <= cand_nxt;
      end
    end
  end

endmodule

// File: rtl/gray_position_decoder.sv
// Gray-coded absolute position decoder: filtered input, binary conversion,
// step/direction tracking and jump detection. Optional turn counter: GRAY_TURN_COUNT_EN.
module gray_position_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         gray_in,
  input  logic                     en,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         pos_out,
  output logic                     pos_valid,
  output logic                     dir,
  output logic                     step_pulse,
`ifdef GRAY_TURN_COUNT_EN
  output logic                     err,
  output logic signed [TURN_W-1:0] turns
`else
  output logic                     err
`endif
);

  logic [WIDTH-1:0] cand;
  logic             accept;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] delta;
  logic             step_up;
  logic             step_dn;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pos_nxt;
  logic             valid_nxt;
  logic             dir_nxt;
  logic             pulse_nxt;
  logic             err_nxt;

  gray_in_filter #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .gray_in(gray_in),
    .cand   (cand),
    .accept (accept)
  );

  assign bin     = WIDTH'(gray2bin(32'(cand)));
  assign delta   = bin - pos_out;
  assign step_up = (delta == WIDTH'(1));
  assign step_dn = (delta == '1);

`ifdef GRAY_TURN_COUNT_EN
  localparam logic signed [TURN_W-1:0] TURN_ONE = TURN_W'(1);
  logic signed [TURN_W-1:0] turns_nxt;
`endif

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_out;
    valid_nxt = pos_valid;
    dir_nxt   = dir;
    pulse_nxt = 1'b0;
    err_nxt   = err;
`ifdef GRAY_TURN_COUNT_EN
    turns_nxt = turns;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = TRACK;
            pos_nxt   = bin;
            valid_nxt = 1'b1;
          end
        end
        TRACK: begin
          if (accept) begin
            if (step_up) begin
              dir_nxt   = 1'b1;
              pulse_nxt = 1'b1;
              pos_nxt   = bin;
`ifdef GRAY_TURN_COUNT_EN
              if (bin == '0) turns_nxt = turns + TURN_ONE;
`endif
            end else if (step_dn) begin
              dir_nxt   = 1'b0;
              pulse_nxt = 1'b1;
              pos_nxt   = bin;
`ifdef GRAY_TURN_COUNT_EN
              if (bin == '1) turns_nxt = turns - TURN_ONE;
`endif
            end else begin
              state_nxt = ERROR;
              err_nxt   = 1'b1;
              valid_nxt = 1'b0;
            end
          end
        end
        ERROR: begin
          // Any accept in this cycle is deliberately dropped.
          if (clear_err) begin
            state_nxt = IDLE;
            err_nxt   = 1'b0;
`ifdef GRAY_TURN_COUNT_EN
            turns_nxt = '0;
`endif
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_out    <= '0;
      pos_valid  <= 1'b0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos_out    <= pos_nxt;
      pos_valid  <= valid_nxt;
      dir        <= dir_nxt;
      step_pulse <= pulse_nxt;
      err        <= err_nxt;
    end
  end

`ifdef GRAY_TURN_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turns <= '0;
    end else begin
      turns <= turns_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_gray_position_decoder.sv
// Bench for gray_position_decoder: directed scenarios followed by random walks,
// checked against a position-level reference model.
module tb_gray_position_decoder;

  localparam int W = 4;
  localparam int S = 2;
  localparam int HOLD = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gray_in;
  logic         en;
  logic         clear_err;
  logic [W-1:0] pos_out;
  logic         pos_valid;
  logic         dir;
  logic         step_pulse;
  logic         err;
`ifdef GRAY_TURN_COUNT_EN
  logic signed [7:0] turns;
`endif

  always #5 clk = ~clk;

  gray_position_decoder #(
    .WIDTH        (W),
    .STABLE_CYCLES(S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .en        (en),
    .clear_err (clear_err),
    .pos_out   (pos_out),
    .pos_valid (pos_valid),
    .dir       (dir),
    .step_pulse(step_pulse),
`ifdef GRAY_TURN_COUNT_EN
    .err       (err),
    .turns     (turns)
`else
    .err       (err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model, kept in terms of binary positions (0 idle, 1 track, 2 error).
  int m_state, m_pos, m_valid, m_dir, m_err, m_last, m_pulses, m_turns;
  int cur_p;
  int pulses_seen;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) pulses_seen++;
  end

  function automatic logic [W-1:0] gray(input int p);
    logic [W-1:0] b;
    b = W'(p);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pos"},   32'(pos_out),   32'(m_pos));
    check({tag, ".valid"}, 32'(pos_valid), 32'(m_valid));
    check({tag, ".dir"},   32'(dir),       32'(m_dir));
    check({tag, ".err"},   32'(err),       32'(m_err));
    check({tag, ".pulse"}, 32'(pulses_seen), 32'(m_pulses));
`ifdef GRAY_TURN_COUNT_EN
    check({tag, ".turns"}, 32'(8'(turns)), 32'(8'(m_turns)));
`endif
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_valid = 0; m_dir = 0; m_err = 0; m_last = 0; m_turns = 0;
  endtask

  task automatic model_accept(input int p);
    int d;
    m_pulses = 0;
    if (p == m_last) return;
    m_last = p;
    if (!en) return;
    if (m_state == 0) begin
      m_state = 1; m_pos = p; m_valid = 1;
    end else if (m_state == 1) begin
      d = (p - m_pos) & ((1 << W) - 1);
      if (d == 1) begin
        if (p == 0) m_turns++;
        m_dir = 1; m_pulses = 1; m_pos = p;
      end else if (d == (1 << W) - 1) begin
        if (p == (1 << W) - 1) m_turns--;
        m_dir = 0; m_pulses = 1; m_pos = p;
      end else begin
        m_state = 2; m_err = 1; m_valid = 0;
      end
    end
  endtask

  task automatic step(input int p, input string tag);
    @(negedge clk);
    gray_in = gray(p);
    cur_p = p;
    pulses_seen = 0;
    repeat (HOLD) @(negedge clk);
    model_accept(p);
    check_all(tag);
  endtask

  task automatic glitch(input int g, input string tag);
    @(negedge clk);
    gray_in = gray(g);
    pulses_seen = 0;
    @(negedge clk);
    gray_in = gray(cur_p);
    repeat (HOLD) @(negedge clk);
    m_pulses = 0;
    check_all(tag);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear_err = 1'b1;
    pulses_seen = 0;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
    m_pulses = 0;
    if (en && m_state == 2) begin
      m_state = 0; m_err = 0; m_turns = 0;
    end
    check_all(tag);
  endtask

  initial begin
    int r, p;
    rst_n = 1'b0;
    en = 1'b1;
    clear_err = 1'b0;
    gray_in = gray(4);
    cur_p = 4;
    pulses_seen = 0;
    model_reset();
    m_pulses = 0;
    repeat (2) @(negedge clk);
    check_all("reset");

    // First acquisition: outputs change exactly on edge 2+S.
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("acq_edge3.valid", 32'(pos_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    check("acq_edge4.valid", 32'(pos_valid), 32'(1));
    check("acq_edge4.pos",   32'(pos_out),   32'(4));
    repeat (2) @(negedge clk);
    model_accept(4);
    check_all("acquire");

    step(5, "up5");
    step(4, "down4");

    for (int i = 5; i <= 15; i++) step(i, "walk_up");
    step(0, "wrap_up");
    step(15, "wrap_down");
    for (int i = 0; i <= 4; i++) step(i, "back_to4");

    glitch(5, "glitch");
    step(4, "same_code");

    step(6, "jump");
    step(7, "err_ignore7");
    step(3, "err_ignore3");
    do_clear("clear");
    step(9, "reacquire");

    @(negedge clk);
    en = 1'b0;
    step(10, "en_off");
    @(negedge clk);
    en = 1'b1;
    step(10, "en_back");
    step(11, "after_lost");
    do_clear("clear2");
    step(12, "reacquire2");

    // Asynchronous reset in the middle of filtering a new code.
    @(negedge clk);
    gray_in = gray(13);
    cur_p = 13;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    m_pulses = 0;
    pulses_seen = 0;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pulses_seen = 0;
    repeat (HOLD) @(negedge clk);
    model_accept(13);
    check_all("post_reset");

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        p = ($urandom_range(0, 1) != 0) ? cur_p + 1 : cur_p - 1;
        step(p & 15, "rnd_step");
      end else if (r == 6) begin
        step($urandom_range(0, 15), "rnd_jump");
      end else if (r == 7) begin
        glitch((cur_p + $urandom_range(1, 15)) & 15, "rnd_glitch");
      end else begin
        @(negedge clk);
        en = 1'b0;
        step((cur_p + 1) & 15, "rnd_en_off");
        @(negedge clk);
        en = 1'b1;
      end
      if (m_state == 2 && $urandom_range(0, 1) != 0) do_clear("rnd_clear");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
